// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers one completed result per functional unit and
// forwards them round-robin, one per cycle, onto the ROB's single result port.
// Output is registered so the ROB sees a clean pulse; a flush drops everything.
module wb_arbiter #(
  parameter int SRC_NUM      = 3,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             flush,
  input  logic [SRC_NUM-1:0]               src_valid,
  output logic [SRC_NUM-1:0]               src_ready,
  input  logic [SRC_NUM*ROB_ID_WIDTH-1:0]  src_rob_id,
  input  logic [SRC_NUM*32-1:0]            src_data,
  input  logic [SRC_NUM-1:0]               src_set_jump_addr,
  output logic                             out_rdy,
  output logic [ROB_ID_WIDTH-1:0]          out_rob_id,
  output logic [31:0]                      out_data,
  output logic                             out_set_jump_addr
);

  localparam int PTR_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

  logic [SRC_NUM-1:0]      hold_valid;
  logic [ROB_ID_WIDTH-1:0] hold_id   [SRC_NUM];
  logic [31:0]             hold_data [SRC_NUM];
  logic                    hold_jmp  [SRC_NUM];

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [SRC_NUM-1:0] grant;
  logic               grant_found;

  // Scan slots starting at ptr, wrapping modulo SRC_NUM, and pick the first full one
  always_comb begin : grant_sel
    logic [PTR_W:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(SRC_NUM)) begin
        idx = idx - (PTR_W+1)'(SRC_NUM);
      end
      if (!grant_found && hold_valid[idx[PTR_W-1:0]]) begin
        grant_found                = 1'b1;
        grant[idx[PTR_W-1:0]]      = 1'b1;
        grant_idx                  = idx[PTR_W-1:0];
      end
    end
  end

  // Pointer advances to the slot after the winner, never reaching SRC_NUM
  always_comb begin
    ptr_next = grant_idx + PTR_W'(1);
    if (grant_idx == PTR_W'(SRC_NUM - 1)) begin
      ptr_next = '0;
    end
  end

  // A slot accepts when empty or when it is being drained on this same edge
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      src_ready[i] = rdy_in && !flush && (!hold_valid[i] || grant[i]);
    end
  end

  // Slot capture/drain, pointer update and registered result pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_valid        <= '0;
      ptr               <= '0;
      out_rdy           <= 1'b0;
      out_rob_id        <= '0;
      out_data          <= '0;
      out_set_jump_addr <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        hold_valid        <= '0;
        ptr               <= '0;
        out_rdy           <= 1'b0;
        out_rob_id        <= '0;
        out_data          <= '0;
        out_set_jump_addr <= 1'b0;
      end else begin
        if (grant_found) begin
          out_rdy           <= 1'b1;
          out_rob_id        <= hold_id[grant_idx];
          out_data          <= hold_data[grant_idx];
          out_set_jump_addr <= hold_jmp[grant_idx];
          ptr               <= ptr_next;
        end else begin
          out_rdy <= 1'b0;
        end
        for (int i = 0; i < SRC_NUM; i++) begin
          if (src_valid[i] && src_ready[i]) begin
            hold_valid[i] <= 1'b1;
            hold_id[i]    <= src_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
            hold_data[i]  <= src_data[i*32 +: 32];
            hold_jmp[i]   <= src_set_jump_addr[i];
          end else if (grant[i]) begin
            hold_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus a randomized run, all
// compared against a slot/queue-level reference model of the arbiter.
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int IW = 4;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            rdy_in = 1'b1;
  logic            flush  = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_ready;
  logic [N*IW-1:0] src_rob_id = '0;
  logic [N*32-1:0] src_data = '0;
  logic [N-1:0]    src_set_jump_addr = '0;
  logic            out_rdy;
  logic [IW-1:0]   out_rob_id;
  logic [31:0]     out_data;
  logic            out_set_jump_addr;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_valid [N];
  logic [3:0]  m_id    [N];
  logic [31:0] m_data  [N];
  bit          m_jmp   [N];
  int          m_ptr;
  bit          m_out_rdy;
  logic [3:0]  m_out_id;
  logic [31:0] m_out_data;
  bit          m_out_jmp;

  wb_arbiter #(.SRC_NUM(N), .ROB_ID_WIDTH(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rob_id(src_rob_id),
    .src_data(src_data), .src_set_jump_addr(src_set_jump_addr),
    .out_rdy(out_rdy), .out_rob_id(out_rob_id), .out_data(out_data),
    .out_set_jump_addr(out_set_jump_addr)
  );

  always #5 clk_in = ~clk_in;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (m_valid[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_grant();
    r = '0;
    for (int i = 0; i < N; i++) r[i] = rdy_in && !flush && (!m_valid[i] || g == i);
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_ptr = 0; m_out_rdy = 0; m_out_id = '0; m_out_data = '0; m_out_jmp = 0;
  endtask

  task automatic model_update();
    int g;
    logic [N-1:0] rd;
    if (rst_in) m_clear();
    else if (rdy_in) begin
      if (flush) m_clear();
      else begin
        g  = m_grant();
        rd = m_ready();
        if (g >= 0) begin
          m_out_rdy = 1; m_out_id = m_id[g]; m_out_data = m_data[g]; m_out_jmp = m_jmp[g];
          m_ptr = (g + 1) % N;
        end else m_out_rdy = 0;
        for (int i = 0; i < N; i++) begin
          if (src_valid[i] && rd[i]) begin
            m_valid[i] = 1; m_id[i] = src_rob_id[i*IW +: IW];
            m_data[i] = src_data[i*32 +: 32]; m_jmp[i] = src_set_jump_addr[i];
          end else if (g == i) m_valid[i] = 0;
        end
      end
    end
  endtask

  // one clock edge: advance the model with the inputs seen at the edge, end at negedge
  task automatic tick();
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
  endtask

  task automatic set_src(input int i, input bit v, input logic [3:0] id,
                         input logic [31:0] d, input bit j);
    src_valid[i] = v;
    src_rob_id[i*IW +: IW] = id;
    src_data[i*32 +: 32] = d;
    src_set_jump_addr[i] = j;
  endtask

  task automatic idle_inputs();
    src_valid = '0; src_rob_id = '0; src_data = '0; src_set_jump_addr = '0;
    flush = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      src_valid = N'($urandom); src_rob_id = (N*IW)'($urandom);
      src_data = {$urandom, $urandom, $urandom}; rdy_in = c[0];
      tick();
    end
    checks++;
    if (out_rdy !== 1'b0 || out_rob_id !== 4'd0 || out_data !== 32'd0 || out_set_jump_addr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b id=%0d data=%h jmp=%b, want all zero",
               out_rdy, out_rob_id, out_data, out_set_jump_addr);
    end
    checks++;
    if (dut.ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr);
    end
    rst_in = 1'b0; idle_inputs();
    #1;
    checks++;
    if (src_ready !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b want 111", src_ready);
    end
  endtask

  task automatic test_single_source();
    do_reset();
    set_src(1, 1, 4'd5, 32'h1234, 0);
    #1;
    checks++;
    if (src_ready[1] !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b want 1", src_ready[1]);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_rdy !== 1'b0) begin
      errors++; $display("FAIL single_early: out_rdy got %b want 0", out_rdy);
    end
    tick();
    checks++;
    if (out_rdy !== 1'b1 || out_rob_id !== 4'd5 || out_data !== 32'h1234) begin
      errors++;
      $display("FAIL single_out: got rdy=%b id=%0d data=%h, want rdy=1 id=5 data=1234",
               out_rdy, out_rob_id, out_data);
    end
    tick();
    checks++;
    if (out_rdy !== 1'b0 || dut.ptr !== 2'd2) begin
      errors++; $display("FAIL single_after: got rdy=%b ptr=%0d, want rdy=0 ptr=2", out_rdy, dut.ptr);
    end
  endtask

  task automatic test_contention();
    int seq [N];
    int rcount [N];
    logic [N-1:0] rv;
    logic [3:0] oid;
    do_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; rcount[i] = 0; end
    for (int c = 0; c <= 6; c++) begin
      for (int i = 0; i < N; i++)
        set_src(i, 1, 4'(i*4 + seq[i] % 4), $urandom, 0);
      #1;
      rv = src_ready;
      checks++;
      if (rv !== m_ready()) begin
        errors++; $display("FAIL cont_ready c=%0d: got %b want %b", c, rv, m_ready());
      end
      if (c >= 1) for (int i = 0; i < N; i++) if (rv[i]) rcount[i]++;
      tick();
      for (int i = 0; i < N; i++) if (rv[i]) seq[i]++;
      if (c >= 1) begin
        oid = out_rob_id;
        checks++;
        if (out_rdy !== 1'b1 || int'(oid[3:2]) != (c - 1) % 3 || out_rob_id !== m_out_id
            || out_data !== m_out_data) begin
          errors++;
          $display("FAIL cont_grant c=%0d: got rdy=%b src=%0d id=%0d, want rdy=1 src=%0d id=%0d",
                   c, out_rdy, oid[3:2], oid, (c - 1) % 3, m_out_id);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rcount[i] != 2) begin
        errors++; $display("FAIL cont_fair src=%0d: ready count %0d want 2", i, rcount[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) set_src(0, 1, 4'(c + 1), 32'(c * 16), 0);
      else idle_inputs();
      #1;
      if (c < 4) begin
        checks++;
        if (src_ready[0] !== 1'b1) begin
          errors++; $display("FAIL stream_ready c=%0d: got %b want 1", c, src_ready[0]);
        end
      end
      tick();
      if (c >= 1) begin
        checks++;
        if (out_rdy !== 1'b1 || out_rob_id !== 4'(c) || out_data !== 32'((c - 1) * 16)) begin
          errors++;
          $display("FAIL stream_out c=%0d: got rdy=%b id=%0d, want rdy=1 id=%0d", c, out_rdy, out_rob_id, c);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_src(0, 1, 4'hA, 32'hAAAA, 0);
    set_src(2, 1, 4'hC, 32'hCCCC, 0);
    tick();
    idle_inputs();
    flush = 1'b1;
    set_src(1, 1, 4'hB, 32'hBBBB, 0);
    #1;
    checks++;
    if (src_ready !== 3'b000) begin
      errors++; $display("FAIL flush_ready_during: got %b want 000", src_ready);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (out_rdy !== 1'b0 || dut.ptr !== 2'd0 || src_ready !== 3'b111) begin
      errors++;
      $display("FAIL flush_after: got rdy=%b ptr=%0d ready=%b, want 0 0 111", out_rdy, dut.ptr, src_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_rdy !== 1'b0) begin
        errors++; $display("FAIL flush_leak c=%0d: out_rdy got %b id=%0d want 0", c, out_rdy, out_rob_id);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_src(1, 1, 4'd7, 32'h77, 0);
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 1, 4'(9 + i), 32'hDEAD, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (src_ready !== 3'b000) begin
        errors++; $display("FAIL stall_ready c=%0d: got %b want 000", c, src_ready);
      end
      tick();
      checks++;
      if (out_rdy !== 1'b0 || dut.ptr !== 2'd0 || dut.hold_valid !== 3'b010) begin
        errors++;
        $display("FAIL stall_hold c=%0d: got rdy=%b ptr=%0d slots=%b, want 0 0 010",
                 c, out_rdy, dut.ptr, dut.hold_valid);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (out_rdy !== 1'b1 || out_rob_id !== 4'd7 || out_data !== 32'h77 || out_set_jump_addr !== 1'b0) begin
      errors++;
      $display("FAIL stall_emit: got rdy=%b id=%0d data=%h jmp=%b, want 1 7 77 0",
               out_rdy, out_rob_id, out_data, out_set_jump_addr);
    end
    tick();
    checks++;
    if (out_rdy !== 1'b0) begin
      errors++; $display("FAIL stall_once: out_rdy got %b want 0", out_rdy);
    end
  endtask

  task automatic test_jump_flag();
    do_reset();
    set_src(2, 1, 4'd3, 32'h80, 1);
    tick();
    idle_inputs();
    tick();
    checks++;
    if (out_rdy !== 1'b1 || out_set_jump_addr !== 1'b1 || out_data !== 32'h80 || out_rob_id !== 4'd3) begin
      errors++;
      $display("FAIL jump_out: got rdy=%b jmp=%b data=%h id=%0d, want 1 1 80 3",
               out_rdy, out_set_jump_addr, out_data, out_rob_id);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_in = ($urandom_range(0, 59) == 0);
      rdy_in = ($urandom_range(0, 5) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++)
        set_src(i, $urandom_range(0, 2) != 0, 4'($urandom), $urandom, 1'($urandom));
      #1;
      checks++;
      if (src_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, src_ready, m_ready());
      end
      tick();
      checks++;
      if (out_rdy !== m_out_rdy || out_rob_id !== m_out_id || out_data !== m_out_data
          || out_set_jump_addr !== m_out_jmp || dut.ptr !== 2'(m_ptr)) begin
        errors++;
        $display("FAIL rand_out c=%0d: got rdy=%b id=%0d data=%h jmp=%b ptr=%0d, want %b %0d %h %b %0d",
                 c, out_rdy, out_rob_id, out_data, out_set_jump_addr, dut.ptr,
                 m_out_rdy, m_out_id, m_out_data, m_out_jmp, m_ptr);
      end
    end
    rst_in = 1'b0;
    idle_inputs();
  endtask

  initial begin
    m_clear();
    for (int i = 0; i < N; i++) begin m_id[i] = '0; m_data[i] = '0; m_jmp[i] = 0; end
    @(negedge clk_in);
    test_reset();
    test_single_source();
    test_contention();
    test_streaming();
    test_flush();
    test_stall();
    test_jump_flag();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Result-bus (writeback) arbiter for the reorder buffer's single execution-result update port (`rs_rdy`/`rs_rob_id`/`rs_data`/`rs_set_jump_addr`). It buffers one completed result per functional unit (ALU, branch unit, multiplier, …) and grants the bus round-robin, one result per cycle. The output is registered, so the ROB sees at most one clean update pulse per cycle. All pending results are dropped on a misprediction flush.

## Interface
- `SRC_NUM`, default 3: number of requesting functional units (≥2).
- `ROB_ID_WIDTH`, default 4: ROB index width; must equal `` `ROB_WIDTH ``.
- `clk_in`  input  1: clock. All state updates on the rising edge.
- `rst_in`  input  1: reset, synchronous, active-high.
- `rdy_in`  input  1: global enable. When low, all state holds.
- `flush`  input  1: misprediction flush from the ROB. Takes effect only when `rdy_in` is high.
- `src_valid`  input  SRC_NUM: source i presents a result.
- `src_ready`  output  SRC_NUM: source i's result is accepted this edge if `src_valid[i]` is also high.
- `src_rob_id`  input  SRC_NUM*ROB_ID_WIDTH: flattened ROB ids; slice i is `[i*ROB_ID_WIDTH +: ROB_ID_WIDTH]`.
- `src_data`  input  SRC_NUM*32: flattened result data.
- `src_set_jump_addr`  input  SRC_NUM: the result is a jump target rather than a register value.
- `out_rdy`  output  1: one-cycle result pulse to the ROB.
- `out_rob_id`  output  ROB_ID_WIDTH: ROB entry being completed.
- `out_data`  output  32: result or jump target.
- `out_set_jump_addr`  output  1: forwarded flag.

## Operation
- Per-source holding slot: `hold_valid[i]`, `hold_id[i]`, `hold_data[i]`, `hold_jmp[i]`.
- Round-robin pointer `ptr` (clog2(SRC_NUM) bits, minimum 1 bit).
- Grant selection (combinational): the first i with `hold_valid[i]`, scanning `ptr, ptr+1, …, SRC_NUM-1, 0, …, ptr-1` with wrap modulo SRC_NUM. The result is at most one-hot `grant`.
- `src_ready[i] = rdy_in && !flush && (!hold_valid[i] || grant[i])`.
- A freed slot can therefore be refilled on the same edge it is granted. This gives one result per cycle per source when that source is the only requester.
- Edge behaviour with `rdy_in` high and no flush/reset:
  - On a grant of g: `out_rdy<=1`, `out_rob_id<=hold_id[g]`, `out_data<=hold_data[g]`, `out_set_jump_addr<=hold_jmp[g]`, and `ptr<=(g+1) mod SRC_NUM`.
  - With no grant: `out_rdy<=0` and the other outputs hold their values. `ptr` is unchanged.
  - For each i: on capture (`src_valid[i] && src_ready[i]`), load the slot and set `hold_valid[i]<=1`. If granted without a capture, `hold_valid[i]<=0`.
- The block never reorders results from a single source. Results from different sources carry no ordering guarantee; the ROB does not need one.
- The block does not inspect ROB ids. Uniqueness of ids is guaranteed upstream.

## Timing
- Reset (`rst_in`, regardless of `rdy_in`): all `hold_valid` 0, `ptr` 0, `out_rdy` 0, `out_rob_id` 0, `out_data` 0, `out_set_jump_addr` 0. `src_ready` reads all-ones in the first cycle after reset if `rdy_in` is high and `flush` is low.
- Flush (`flush && rdy_in`): same clearing as reset.
  - The capture on that edge is suppressed, because `src_ready` is low.
  - Any result being granted on that edge is discarded; `out_rdy` goes to 0.
- `rdy_in` low: no capture (`src_ready` is 0) and no state change. `out_rdy` keeps its value. The ROB also ignores it while stalled, so a held pulse is not double-counted.
- Latency: a result captured at edge N appears on `out_*` after edge N+1 at the earliest, i.e. a minimum of 1 cycle in the slot. Worst case is SRC_NUM cycles in the slot under full contention.
- Fairness: with all slots continuously full, each source is granted exactly once every SRC_NUM cycles.
- `ptr` wraps from SRC_NUM-1 to 0. If SRC_NUM is not a power of two, `ptr` must never take values ≥ SRC_NUM.
- `out_rdy` is a registered one-cycle pulse per grant. Back-to-back grants give a continuously high `out_rdy` with a new id each cycle.

## Test plan
- **Reset, single source:** reset, then source 1 presents id 5, data 0x1234 for one cycle → `out_rdy`=1 with id 5, data 0x1234 exactly one cycle after capture. Then `ptr`=2 and `out_rdy`=0 the next cycle.
- **Full contention:** all 3 sources hold valid results continuously from `ptr`=0 → grants cycle 0,1,2,0,1,2. `out_rdy` stays high for 6 cycles, and each source's `src_ready` is high exactly once per 3 cycles.
- **Streaming:** source 0 streams ids 1,2,3,4 on consecutive cycles with the others idle → outputs ids 1,2,3,4 on 4 consecutive cycles with no bubble.
- **Flush:** with slots 0 and 2 full and a grant in progress, assert `flush` → next cycle `out_rdy`=0, all `src_ready` high, `ptr`=0, and neither held result is ever emitted.
- **Stall:** with slot 1 full, drop `rdy_in` for 3 cycles → no capture, `ptr` and slots unchanged. After `rdy_in` returns, the slot 1 result is emitted once.
- **Jump flag:** source 2 sends `set_jump_addr`=1 with data 0x80 → `out_set_jump_addr`=1 and `out_data`=0x80 on the same output cycle.
